// File: rtl/updown_wrap_counter_if.sv
// Bus interface for updown_wrap_counter: control inputs, count outputs and,
// when the TC_STICKY_EN macro is defined, the sticky wrap flag and its clear.
// master = the block driving the counter, slave = the counter itself.
interface updown_wrap_counter_if #(
  parameter int WIDTH = 5
);
  logic             en;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             wrap;
`ifdef TC_STICKY_EN
  logic             tc_sticky;
  logic             tc_clr;

  modport master (
    output en, mode, load, load_val, limit, tc_clr,
    input  cnt, tc, wrap, tc_sticky
  );

  modport slave (
    input  en, mode, load, load_val, limit, tc_clr,
    output cnt, tc, wrap, tc_sticky
  );
`else
  modport master (
    output en, mode, load, load_val, limit,
    input  cnt, tc, wrap
  );

  modport slave (
    input  en, mode, load, load_val, limit,
    output cnt, tc, wrap
  );
`endif
endinterface

// File: rtl/updown_wrap_counter.sv
// Up/down counter with a runtime wrap limit, parallel load, enable and
// terminal-count detection. Count range is 0..limit in either direction.
// Optional feature: define TC_STICKY_EN to add a sticky wrap flag (tc_sticky)
// with its clear strobe (tc_clr); without it that logic does not exist.
module updown_wrap_counter #(
  parameter int               WIDTH   = 5,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  updown_wrap_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;
  logic             r_wrap;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_wrap_nxt;
  logic             w_tc;

  // Next count and wrap: load beats enable; a value above limit wraps on the
  // next up step, and a down step below zero reloads limit.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    w_cnt_nxt  = r_cnt;
    w_wrap_nxt = 1'b0;
    if (bus.load) begin
      w_cnt_nxt = bus.load_val;
    end else if (bus.en) begin
      if (!bus.mode) begin
        if (r_cnt >= bus.limit) begin
          w_cnt_nxt  = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + ONE;
        end
      end else begin
        if (r_cnt == '0) begin
          w_cnt_nxt  = bus.limit;
          w_wrap_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - ONE;
        end
      end
    end
  end

  // Count and wrap-pulse registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_cnt  <= RST_VAL;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  // Terminal count is combinational so it is visible in the same cycle.
  assign w_tc = bus.mode ? (r_cnt == '0) : (r_cnt >= bus.limit);

  assign bus.cnt  = r_cnt;
  assign bus.wrap = r_wrap;
  assign bus.tc   = w_tc;

`ifdef TC_STICKY_EN
  logic r_tc_sticky;

  // Sticky wrap flag: a wrap on this edge beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tc_sticky <= 1'b0;
    end else if (w_wrap_nxt) begin
      r_tc_sticky <= 1'b1;
    end else if (bus.tc_clr) begin
      r_tc_sticky <= 1'b0;
    end
  end

  assign bus.tc_sticky = r_tc_sticky;
`endif

endmodule

// File: tb/tb_updown_wrap_counter.sv
// Scoreboard bench for updown_wrap_counter: stimulus drives inputs on the
// falling edge and pushes the reference model's expected state; a monitor
// pops and compares just after each rising edge.
module tb_updown_wrap_counter;

  localparam int W = 5;
  localparam logic [W-1:0] RST_VAL = '0;

  typedef struct {
    string      name;
    logic [W-1:0] cnt;
    logic       wrap;
    logic       tc;
    logic       sticky;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   n_total  = 0;
  int   n_passed = 0;

  // Reference state: plain integers, updated with the counter's rules.
  int m_cnt    = 0;
  int m_sticky = 0;

  updown_wrap_counter_if #(.WIDTH(W)) bus ();

  updown_wrap_counter #(.WIDTH(W), .RST_VAL(RST_VAL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_passed++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // One clock of stimulus; the model computes what the DUT must show after the edge.
  task automatic step(input string name, input logic rn, input logic en,
                      input logic mode, input logic ld, input int lv,
                      input int lim, input logic clr);
    exp_t e;
    int   wrap;
    @(negedge clk);
    rst_n        = rn;
    bus.en       = en;
    bus.mode     = mode;
    bus.load     = ld;
    bus.load_val = W'(lv);
    bus.limit    = W'(lim);
`ifdef TC_STICKY_EN
    bus.tc_clr   = clr;
`endif
    wrap = 0;
    if (!rn) begin
      m_cnt = int'(RST_VAL);
    end else if (ld) begin
      m_cnt = lv;
    end else if (en && !mode) begin
      if (m_cnt >= lim) begin m_cnt = 0; wrap = 1; end
      else m_cnt = m_cnt + 1;
    end else if (en && mode) begin
      if (m_cnt == 0) begin m_cnt = lim; wrap = 1; end
      else m_cnt = m_cnt - 1;
    end
    if (!rn) m_sticky = 0;
    else if (wrap == 1) m_sticky = 1;
    else if (clr) m_sticky = 0;
    e.name   = name;
    e.cnt    = W'(m_cnt);
    e.wrap   = (wrap == 1);
    e.tc     = mode ? (m_cnt == 0) : (m_cnt >= lim);
    e.sticky = (m_sticky == 1);
    exp_q.push_back(e);
  endtask

  // Monitor: every output cycle with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".cnt"},  int'(bus.cnt),  int'(e.cnt));
        check({e.name, ".wrap"}, int'(bus.wrap), int'(e.wrap));
        check({e.name, ".tc"},   int'(bus.tc),   int'(e.tc));
`ifdef TC_STICKY_EN
        check({e.name, ".sticky"}, int'(bus.tc_sticky), int'(e.sticky));
`endif
      end
    end
  end

  initial begin
    int waited;
    rst_n        = 1'b0;
    bus.en       = 1'b1;
    bus.mode     = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.limit    = '0;
`ifdef TC_STICKY_EN
    bus.tc_clr   = 1'b0;
`endif

    // Reset held two cycles with en high, limit 0, mode up.
    step("reset0", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    step("reset1", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

    // Count up 0..30, wrap to 0, then one more step.
    for (int i = 0; i < 32; i++) step("up30", 1'b1, 1'b1, 1'b0, 1'b0, 0, 30, 1'b0);

    // Count down from 0: wraps to 30, then 29, 28.
    step("ld0", 1'b1, 1'b0, 1'b0, 1'b1, 0, 30, 1'b0);
    for (int i = 0; i < 3; i++) step("down30", 1'b1, 1'b1, 1'b1, 1'b0, 0, 30, 1'b0);

    // Load beats count enable.
    step("ld10", 1'b1, 1'b0, 1'b0, 1'b1, 10, 30, 1'b0);
    step("ldwin", 1'b1, 1'b1, 1'b1, 1'b1, 25, 30, 1'b0);

    // Count above a lowered limit: up wraps to 0, down decrements.
    step("ld20a", 1'b1, 1'b0, 1'b0, 1'b1, 20, 30, 1'b0);
    step("over_up", 1'b1, 1'b1, 1'b0, 1'b0, 0, 12, 1'b0);
    step("ld20b", 1'b1, 1'b0, 1'b0, 1'b1, 20, 30, 1'b0);
    step("over_dn", 1'b1, 1'b1, 1'b1, 1'b0, 0, 12, 1'b0);

    // Hold with en low.
    step("hold", 1'b1, 1'b0, 1'b1, 1'b0, 0, 12, 1'b0);

    // limit 0: wraps 0->0 every enabled edge in both directions.
    step("ld0b", 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    step("lim0_up", 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    step("lim0_up2", 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    step("lim0_dn", 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);

    // Full-range boundary: limit 31, up from 31 wraps to 0.
    step("ld31", 1'b1, 1'b0, 1'b0, 1'b1, 31, 31, 1'b0);
    step("max_up", 1'b1, 1'b1, 1'b0, 1'b0, 0, 31, 1'b0);

    // Wrap together with clear keeps the sticky flag; clear alone drops it.
    step("ld3", 1'b1, 1'b0, 1'b0, 1'b1, 3, 3, 1'b0);
    step("wrap_clr", 1'b1, 1'b1, 1'b0, 1'b0, 0, 3, 1'b1);
    step("clr_only", 1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 1'b1);

    // Reset mid-count at 17 after a wrap set the sticky flag.
    step("ld30", 1'b1, 1'b0, 1'b0, 1'b1, 30, 30, 1'b0);
    step("wrap30", 1'b1, 1'b1, 1'b0, 1'b0, 0, 30, 1'b0);
    step("ld17", 1'b1, 1'b0, 1'b0, 1'b1, 17, 30, 1'b0);
    step("mid_rst", 1'b0, 1'b1, 1'b0, 1'b0, 0, 30, 1'b0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 39) != 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 31)),
           (i % 50 < 25) ? 7 : int'($urandom_range(0, 31)),
           ($urandom_range(0, 4) == 0));
    end

    // Drain the scoreboard within a bounded number of cycles.
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    check("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
